// File: rtl/stream_merge_2_1_pkg.sv
// rtl/stream_merge_2_1_pkg.sv - shared constants for the 2-to-1 stream merger
package stream_merge_2_1_pkg;

  localparam int SEL_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [SEL_WIDTH-1:0] SRC_00 = 8'd0;
  localparam logic [SEL_WIDTH-1:0] SRC_01 = 8'd1;

  function automatic logic [1:0] grant_state(input logic src);
    return src ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - single-entry valid/ready output register
module stream_reg_slice #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  // A new beat may replace the held one in the same cycle it is consumed.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      out_payload <= in_payload;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_merge_2_1.sv
// rtl/stream_merge_2_1.sv - burst-limited round-robin 2-to-1 stream merger
module stream_merge_2_1
  import stream_merge_2_1_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_00_data,
  input  logic                 in_00_valid,
  output logic                 in_00_ready,
  input  logic [WIDTH-1:0]     in_01_data,
  input  logic                 in_01_valid,
  output logic                 in_01_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_select,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_W = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 last_grant;
  logic                 gnt0;
  logic                 gnt1;
  logic                 cur_valid;
  logic                 oth_valid;
  logic                 slice_ready;
  logic                 accept;
  logic                 leave;
  logic [WIDTH-1:0]     cur_data;
  logic [SEL_WIDTH-1:0] cur_sel;

  always_comb begin
    gnt0      = (state == ST_GNT0);
    gnt1      = (state == ST_GNT1);
    cur_valid = (gnt0 && in_00_valid) || (gnt1 && in_01_valid);
    oth_valid = gnt0 ? in_01_valid : in_00_valid;
    cur_data  = gnt1 ? in_01_data : in_00_data;
    cur_sel   = gnt1 ? SRC_01 : SRC_00;
    accept    = cur_valid && slice_ready;
    // Grant ends on the last beat of a burst or as soon as the owner goes idle.
    leave     = (accept && (beat_cnt == CNT_LAST)) || !cur_valid;
  end

  assign in_00_ready = gnt0 && slice_ready;
  assign in_01_ready = gnt1 && slice_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (in_00_valid && in_01_valid) begin
            state <= grant_state(!last_grant);
          end else if (in_00_valid) begin
            state <= ST_GNT0;
          end else if (in_01_valid) begin
            state <= ST_GNT1;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (leave) begin
            beat_cnt <= '0;
            if (oth_valid) begin
              state      <= grant_state(!gnt1);
              last_grant <= gnt1;
            end else if (!cur_valid) begin
              state      <= ST_IDLE;
              last_grant <= gnt1;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  stream_reg_slice #(
    .WIDTH(WIDTH + SEL_WIDTH)
  ) u_out_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (cur_valid),
    .in_ready   (slice_ready),
    .in_payload ({cur_sel, cur_data}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload({out_select, out_data})
  );

endmodule

// File: tb/tb_stream_merge_2_1.sv
// tb/tb_stream_merge_2_1.sv - directed and randomized bench for stream_merge_2_1
module tb_stream_merge_2_1;

  localparam int WIDTH = 16;
  localparam int BL    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_00_data = '0;
  logic             in_00_valid = 1'b0;
  logic             in_00_ready;
  logic [WIDTH-1:0] in_01_data = '0;
  logic             in_01_valid = 1'b0;
  logic             in_01_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_select;
  logic             out_valid;
  logic             out_ready = 1'b0;

  stream_merge_2_1 #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_00_data (in_00_data),
    .in_00_valid(in_00_valid),
    .in_00_ready(in_00_ready),
    .in_01_data (in_01_data),
    .in_01_valid(in_01_valid),
    .in_01_ready(in_01_ready),
    .out_data   (out_data),
    .out_select (out_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] pend0[$], pend1[$], exp0[$], exp1[$];
  int  sel_log[$], out_cyc[$];
  int  cyc = 0, nout = 0, wait0 = 0, wait1 = 0;
  bit  hs0 = 0, hs1 = 0, hso = 0;
  bit  rand_mode = 0, gen = 0;
  int  p_valid = 100, p_ready = 100;
  logic fixed_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sources only present a new beat after the previous one handshook.
  task automatic drive();
    if (gen && pend0.size() == 0) pend0.push_back(WIDTH'($urandom));
    if (gen && pend1.size() == 0) pend1.push_back(WIDTH'($urandom));
    if (!in_00_valid || hs0) begin
      in_00_valid = (pend0.size() > 0) && ($urandom_range(0, 99) < p_valid);
      in_00_data  = in_00_valid ? pend0[0] : WIDTH'($urandom);
    end
    if (!in_01_valid || hs1) begin
      in_01_valid = (pend1.size() > 0) && ($urandom_range(0, 99) < p_valid);
      in_01_data  = in_01_valid ? pend1[0] : WIDTH'($urandom);
    end
    out_ready = rand_mode ? ($urandom_range(0, 99) < p_ready) : fixed_ready;
    hs0 = 0;
    hs1 = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    hs0 = in_00_valid && in_00_ready;
    hs1 = in_01_valid && in_01_ready;
    hso = out_valid && out_ready;
    if (hso) begin
      sel_log.push_back(int'(out_select));
      out_cyc.push_back(cyc);
      nout++;
      if (out_select == 8'd0) begin
        chk("sb_avail0", 32'(exp0.size() > 0), 1);
        if (exp0.size() > 0) chk("sb_data0", 32'(out_data), 32'(exp0.pop_front()));
      end else if (out_select == 8'd1) begin
        chk("sb_avail1", 32'(exp1.size() > 0), 1);
        if (exp1.size() > 0) chk("sb_data1", 32'(out_data), 32'(exp1.pop_front()));
      end else begin
        chk("sb_select", 32'(out_select), 0);
      end
    end
    if (in_00_valid && !hs0) begin if (hs1) wait0++; end else wait0 = 0;
    if (in_01_valid && !hs1) begin if (hs0) wait1++; end else wait1 = 0;
    if (rand_mode) begin
      chk("fair0", 32'(wait0 <= BL), 1);
      chk("fair1", 32'(wait1 <= BL), 1);
    end
    if (hs0) begin exp0.push_back(in_00_data); void'(pend0.pop_front()); end
    if (hs1) begin exp1.push_back(in_01_data); void'(pend1.pop_front()); end
    @(posedge clk);
    cyc++;
    #1;
    drive();
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ready0", 32'(in_00_ready), 0);
    chk("rst_ready1", 32'(in_01_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_select", 32'(out_select), 0);
    rst_n = 1'b1;

    // Single source: bubble, 1-cycle latency, 1 beat/cycle across burst wrap
    fixed_ready = 1'b1;
    for (int i = 1; i <= 6; i++) pend0.push_back(WIDTH'(i));
    drive();
    #1;
    chk("t2_idle_ready", 32'(in_00_ready), 0);
    tick();
    chk("t2_grant_ready", 32'(in_00_ready), 1);
    chk("t2_no_out_yet", 32'(out_valid), 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_out_valid", 32'(out_valid), 1);
      chk("t2_out_data", 32'(out_data), 32'(k));
      chk("t2_out_select", 32'(out_select), 0);
    end
    tick();
    chk("t2_out_drained", 32'(out_valid), 0);
    chk("t2_queue_empty", 32'(exp0.size()), 0);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 10; i++) begin
      pend0.push_back(WIDTH'(16'h0a00 + i));
      pend1.push_back(WIDTH'(16'h0b00 + i));
    end
    drive();
    #1;
    repeat (3) tick();
    chk("t1_busy", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_out_valid", 32'(out_valid), 0);
    chk("t1_ready0", 32'(in_00_ready), 0);
    chk("t1_ready1", 32'(in_01_ready), 0);
    chk("t1_out_data", 32'(out_data), 0);
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    in_00_valid = 1'b0;
    in_01_valid = 1'b0;
    hs0 = 0;
    hs1 = 0;
    wait0 = 0;
    wait1 = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Both sources continuously: bursts of BL alternating, source 0 first
    for (int i = 0; i < 16; i++) begin
      pend0.push_back(WIDTH'(16'h0300 + i));
      pend1.push_back(WIDTH'(16'h0400 + i));
    end
    drive();
    #1;
    chk("t1_idle_ready0", 32'(in_00_ready), 0);
    chk("t1_idle_ready1", 32'(in_01_ready), 0);
    sel_log.delete(); out_cyc.delete(); nout = 0;
    for (int i = 0; i < 200 && nout < 32; i++) tick();
    chk("t3_count", 32'(nout), 32);
    if (nout == 32) begin
      for (int i = 0; i < 32; i++) chk("t3_select_seq", 32'(sel_log[i]), 32'((i / BL) % 2));
      for (int i = 1; i < 32; i++) chk("t3_no_bubble", 32'(out_cyc[i] - out_cyc[i-1]), 1);
    end

    // Backpressure: held beat stays put, source sees no ready
    nout = 0;
    for (int i = 0; i < 8; i++) pend0.push_back(WIDTH'(16'h0500 + i));
    fixed_ready = 1'b1;
    drive();
    #1;
    repeat (3) tick();
    fixed_ready = 1'b0;
    out_ready   = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_data", 32'(out_data), 32'h0501);
      chk("t4_hold_select", 32'(out_select), 0);
      chk("t4_ready_low", 32'(in_00_ready), 0);
      tick();
    end
    fixed_ready = 1'b1;
    for (int i = 0; i < 50 && (pend0.size() > 0 || exp0.size() > 0 || out_valid); i++) tick();
    chk("t4_beats_out", 32'(nout), 8);
    chk("t4_queue_empty", 32'(exp0.size()), 0);

    // Source 1 goes idle after 2 beats while source 0 waits
    nout = 0;
    sel_log.delete();
    pend1.push_back(16'h0600);
    pend1.push_back(16'h0601);
    drive();
    #1;
    tick();
    for (int i = 0; i < 4; i++) pend0.push_back(WIDTH'(16'h0700 + i));
    drive();
    #1;
    tick();
    tick();
    chk("t5_still_gnt1_r1", 32'(in_01_ready), 1);
    chk("t5_still_gnt1_r0", 32'(in_00_ready), 0);
    tick();
    chk("t5_gnt0_r0", 32'(in_00_ready), 1);
    chk("t5_gnt0_r1", 32'(in_01_ready), 0);
    for (int i = 0; i < 4; i++) pend1.push_back(WIDTH'(16'h0610 + i));
    drive();
    #1;
    for (int i = 0; i < 100 && nout < 10; i++) tick();
    chk("t5_count", 32'(nout), 10);
    if (nout == 10) begin
      for (int i = 0; i < 10; i++)
        chk("t5_select_seq", 32'(sel_log[i]), 32'((i < 2 || i >= 6) ? 1 : 0));
    end

    // Randomized traffic with scoreboard and fairness bound
    nout = 0;
    wait0 = 0;
    wait1 = 0;
    rand_mode = 1;
    gen = 1;
    for (int i = 0; i < 60000 && nout < 10000; i++) begin
      if (i % 2000 == 0) begin
        p_valid = $urandom_range(30, 100);
        p_ready = $urandom_range(30, 100);
      end
      tick();
    end
    chk("t6_beats", 32'(nout >= 10000), 1);
    gen = 0;
    rand_mode = 0;
    p_valid = 100;
    fixed_ready = 1'b1;
    for (int i = 0; i < 200 && (pend0.size() + pend1.size() + exp0.size() + exp1.size() > 0); i++)
      tick();
    chk("t6_drain0", 32'(exp0.size() + pend0.size()), 0);
    chk("t6_drain1", 32'(exp1.size() + pend1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
